// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame length and baud divider helper.
// Optional parity support is selected with UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_t;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - loadable bit-period down-counter; tick marks the last cycle of a bit.
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - stream-fed 8N1 UART transmitter with registered tx line.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  if (DIV < 2) begin : g_div_too_small
    $error("uart_tx_stream: CLK_HZ/BAUD must give at least 2 cycles per bit");
  end

  uart_state_t state, state_next;
  logic [7:0]  data;
  logic [2:0]  idx, idx_next;
  logic        tx_next;
  logic        load;
  logic        tick;
  logic        take;

  assign in_ready = (state == IDLE) && !rst;
  assign take     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .tick (tick)
  );

  // tx_next is the level for the next bit; it only moves on a bit boundary.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    tx_next    = tx;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_next = START;
          tx_next    = 1'b0;
          load       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          idx_next   = 3'd0;
          tx_next    = data[0];
          load       = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          load = 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = ^data;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            idx_next = idx + 3'd1;
            tx_next  = data[idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
          load       = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      idx   <= 3'd0;
      data  <= 8'h00;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      idx   <= idx_next;
      if (take) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Byte-serial UART transmitter that drains the byte FIFO's read side.
- Accepts 8-bit words over a valid/ready stream and shifts each out as an 8N1 frame on a single TX line: start bit, 8 data bits LSB first, stop bit.
- Sits directly downstream of the sync FIFO and feeds the board's UART pin.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV (localparam), CLK_HZ/BAUD rounded to nearest, cycles per bit. Must be >= 2; elaboration error otherwise.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream byte available.
- in_ready  out  1  block can accept a byte this cycle.
- in_data  in  8  byte to transmit, sampled on transfer.
- tx  out  1  serial line, idle high. Registered, no combinational path from inputs.
- busy  out  1  frame in progress (any state other than IDLE).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tx=1, busy=0, state=IDLE, baud counter=0, bit index=0. in_ready=0 while rst is high.
- Handshake:
  - Transfer occurs when in_valid && in_ready in the same cycle.
  - in_ready = (state==IDLE) && !rst. It is combinational from state only and never depends on in_valid.
  - in_data is latched into the shift register on transfer. Upstream may change it afterwards.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: tx=1. On transfer, go to START and load the counter with DIV-1.
  - START: tx=0 for exactly DIV cycles.
  - DATA: bits 0..7, LSB first, each held for exactly DIV cycles. The 3-bit index increments on each bit-end tick. Exit after bit 7.
  - STOP: tx=1 for exactly DIV cycles, then return to IDLE.
- Bit timing:
  - The down-counter reloads to DIV-1 at every bit boundary.
  - A bit ends when the counter==0.
  - tx changes only at bit boundaries, registered.
- Latency:
  - The first start-bit cycle on tx is the cycle after the transfer.
  - Back-to-back frames: one IDLE cycle between stop bit end and next start bit, giving a period of 10*DIV+1 cycles.
- Boundary conditions:
  - in_valid held high continuously: bytes are accepted once per frame, with none dropped and none duplicated.
  - in_valid asserted mid-frame: ignored (in_ready=0) until IDLE.
  - Reset mid-frame: tx=1 on the next cycle, the frame is abandoned, and the byte is lost.
  - rst and in_valid together: no transfer.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting DIV cycles.
  - tx = even parity (XOR of the 8 data bits).
  - Frame becomes 11 bits; back-to-back period is 11*DIV+1.
- Undefined: no PARITY state, no parity logic; 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - a DIV calculation function (rounded CLK_HZ/BAUD);
  - FRAME_BITS constant, 10 or 11 depending on the macro.
- Sub-module uart_baud_gen:
  - loadable down-counter of width $clog2(DIV);
  - inputs clk, rst, load;
  - output tick on count==0.
  - Reused later by the RX side.

Test Plan:
- CLK_HZ=1000000, BAUD=250000 (DIV=4), send 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 cycles; busy high 40 cycles; in_ready returns high the cycle after.
- Send 0x01 then 0xFE with in_valid held high → second start bit begins exactly 41 cycles after the first. Decoded bytes 0x01, 0xFE; in_ready asserted for exactly one accepted transfer per frame.
- Assert in_valid with 0xAA at cycle 15 of a frame carrying 0x0F → not accepted until IDLE. Line shows 0x0F then 0xAA intact.
- Assert rst during DATA bit 3 of 0x00 → tx=1 next cycle, busy=0, in_ready=0 during rst. A byte 0x3C offered after rst deasserts transmits correctly.
- UART_TX_PARITY_EN defined, send 0x07 → parity bit 1; send 0x55 → parity bit 0. Frame 44 cycles at DIV=4.
- Random 256 bytes with random in_valid gaps against a reference UART receiver model → all bytes received in order; no glitches on tx between bit boundaries.
